// File: rtl/types_pkg.sv
// types_pkg: run status and record types shared by the stream source and the pass-through stage
package types_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    typedef struct packed {
        logic [7:0] field1;
        int         field2;
    } my_struct_t;

endpackage

// File: rtl/struct_stream_gen.sv
// struct_stream_gen: start/abort driven source emitting a BEATS-long burst of arithmetic records under valid/ready
module struct_stream_gen
    import types_pkg::*;
#(
    parameter int         BEATS = 16,
    parameter logic [7:0] STEP  = 8'd1,
    parameter int         SEED  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_ready,
    output state_t     o_state,
    output logic       o_valid,
    output my_struct_t o_rec,
    output logic       o_done
);

    localparam int CW = $clog2(BEATS + 1);

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    my_struct_t     rec;
    logic           go, acc, last;

    always_comb begin
        go   = state == IDLE && i_start && !i_abort;
        acc  = state == RUN && i_ready;
        last = acc && cnt == CW'(BEATS - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (go ? RUN : IDLE) :
                   state == RUN  ? ((i_abort || last) ? STOP : RUN) : IDLE;
    end

    // field2 accumulates the pre-increment field1 of every accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec <= '0;
            cnt <= '0;
        end else if (go) begin
            rec.field1 <= 8'd0;
            rec.field2 <= SEED;
            cnt        <= '0;
        end else if (acc) begin
            rec.field1 <= rec.field1 + STEP;
            rec.field2 <= rec.field2 + {24'b0, rec.field1};
            cnt        <= cnt + CW'(1);
        end
    end

    always_comb begin
        o_state = state;
        o_valid = state == RUN;
        o_done  = state == STOP;
        o_rec   = rec;
    end

endmodule
